// File: rtl/wb_dma_if.sv
// Wishbone master-port bundle for the DMA engine. A beat completes on the rising edge
// where cyc & stb & ack are all high; until then the initiator holds adr/we/dat_o/sel steady.
interface wb_dma_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) ();
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [3:0]        wbm_sel_o;
  logic [ADDR_W-1:0] wbm_adr_o;
  logic [DATA_W-1:0] wbm_dat_o;
  logic [DATA_W-1:0] wbm_dat_i;
  logic              wbm_ack_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_dma_master.sv
// Wishbone DMA initiator: copies len words from src to dst in chunks of up to BURST words,
// reading a chunk into a local buffer, writing it out, then releasing cyc for one cycle.
module wb_dma_master #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int BURST  = 4,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [2:0]        state_dbg,
  wb_dma_if.master          wbm
);

  localparam int IDX_W = $clog2(BURST);
  localparam int CNT_W = IDX_W + 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LOAD = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_GAP  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  logic [2:0]        state;
  logic [ADDR_W-1:0] src_ptr, dst_ptr;
  logic [LEN_W-1:0]  remaining;
  logic [CNT_W-1:0]  chunk, rd_cnt, wr_cnt, load_chunk, wr_nxt;
  logic              abort_pend;
  logic [DATA_W-1:0] data_buf [BURST];

  logic ack_ok, abort_now, last_rd, last_wr, finish;

  assign state_dbg = state;
  assign ack_ok    = wbm.wbm_ack_i & wbm.wbm_stb_o;
  assign abort_now = abort_pend | abort;
  assign last_rd   = (rd_cnt == chunk - CNT_W'(1));
  assign last_wr   = (wr_cnt == chunk - CNT_W'(1));
  assign wr_nxt    = wr_cnt + CNT_W'(1);

  always_comb begin
    load_chunk = (remaining >= LEN_W'(BURST)) ? CNT_W'(BURST) : remaining[CNT_W-1:0];
    finish = 1'b0;
    case (state)
      S_LOAD, S_GAP: finish = abort_now || (remaining == '0);
      S_RD:          finish = ack_ok && abort_now;
      S_WR:          finish = ack_ok && (abort_now || (last_wr && remaining == LEN_W'(1)));
      default:       finish = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (state == S_RD && ack_ok) data_buf[rd_cnt[IDX_W-1:0]] <= wbm.wbm_dat_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= S_IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      aborted       <= 1'b0;
      abort_pend    <= 1'b0;
      src_ptr       <= '0;
      dst_ptr       <= '0;
      remaining     <= '0;
      chunk         <= '0;
      rd_cnt        <= '0;
      wr_cnt        <= '0;
      wbm.wbm_cyc_o <= 1'b0;
      wbm.wbm_stb_o <= 1'b0;
      wbm.wbm_we_o  <= 1'b0;
      wbm.wbm_sel_o <= 4'h0;
      wbm.wbm_adr_o <= '0;
      wbm.wbm_dat_o <= '0;
    end else begin
      done <= 1'b0;
      if (abort && state != S_IDLE && state != S_DONE) abort_pend <= 1'b1;
      if (finish) begin
        state         <= S_DONE;
        done          <= 1'b1;
        busy          <= 1'b0;
        aborted       <= abort_now;
        wbm.wbm_cyc_o <= 1'b0;
        wbm.wbm_stb_o <= 1'b0;
        wbm.wbm_we_o  <= 1'b0;
        wbm.wbm_sel_o <= 4'h0;
      end else begin
        case (state)
          S_IDLE: if (start) begin
            src_ptr    <= src_addr & ~ADDR_W'(3);
            dst_ptr    <= dst_addr & ~ADDR_W'(3);
            remaining  <= len;
            aborted    <= 1'b0;
            abort_pend <= 1'b0;
            busy       <= 1'b1;
            state      <= S_LOAD;
          end
          // GAP doubles as the chunk setup so cyc is released for exactly one cycle.
          S_LOAD, S_GAP: begin
            chunk         <= load_chunk;
            rd_cnt        <= '0;
            state         <= S_RD;
            wbm.wbm_cyc_o <= 1'b1;
            wbm.wbm_stb_o <= 1'b1;
            wbm.wbm_we_o  <= 1'b0;
            wbm.wbm_sel_o <= 4'hF;
            wbm.wbm_adr_o <= src_ptr;
          end
          S_RD: if (ack_ok) begin
            src_ptr <= src_ptr + ADDR_W'(4);
            rd_cnt  <= rd_cnt + CNT_W'(1);
            if (last_rd) begin
              state         <= S_WR;
              wr_cnt        <= '0;
              wbm.wbm_we_o  <= 1'b1;
              wbm.wbm_adr_o <= dst_ptr;
              // A one-word chunk has its only word arriving on this very ack.
              wbm.wbm_dat_o <= (rd_cnt == '0) ? wbm.wbm_dat_i : data_buf[0];
            end else begin
              wbm.wbm_adr_o <= src_ptr + ADDR_W'(4);
            end
          end
          S_WR: if (ack_ok) begin
            dst_ptr   <= dst_ptr + ADDR_W'(4);
            wr_cnt    <= wr_nxt;
            remaining <= remaining - LEN_W'(1);
            if (last_wr) begin
              state         <= S_GAP;
              wbm.wbm_cyc_o <= 1'b0;
              wbm.wbm_stb_o <= 1'b0;
              wbm.wbm_we_o  <= 1'b0;
              wbm.wbm_sel_o <= 4'h0;
            end else begin
              wbm.wbm_adr_o <= dst_ptr + ADDR_W'(4);
              wbm.wbm_dat_o <= data_buf[wr_nxt[IDX_W-1:0]];
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_dma_master.sv
// Bench for wb_dma_master: Wishbone slave with random ack delay, a transfer-level model that
// queues expected bus beats and completions, and a monitor that checks them as they occur.
module tb_wb_dma_master;
  localparam int AW = 32, DW = 32, BURST = 4, LW = 16, TW = 1 + AW + DW;

  logic          clk = 1'b0, rst_n = 1'b0, start = 1'b0, abort = 1'b0;
  logic [AW-1:0] src_addr = '0, dst_addr = '0;
  logic [LW-1:0] len = '0;
  logic          busy, done, aborted;
  logic [2:0]    state_dbg;

  wb_dma_if #(.ADDR_W(AW), .DATA_W(DW)) wbm ();

  wb_dma_master #(.ADDR_W(AW), .DATA_W(DW), .BURST(BURST), .LEN_W(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .len(len), .abort(abort), .busy(busy), .done(done), .aborted(aborted),
    .state_dbg(state_dbg), .wbm(wbm)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  logic [TW-1:0] exp_q[$];
  logic          done_q[$];
  logic [31:0]   wmem [logic [31:0]];
  logic [31:0]   seed;
  int dly_lo = 0, dly_hi = 0, txn_cnt = 0, chunk_cnt = 0;
  bit noise = 0;

  function automatic logic [31:0] rd_val(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ seed;
  endfunction

  task automatic check(input string nm, input logic [TW-1:0] act, input logic [TW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transfer-level reference: chunked read-then-write order; stop_reads>=0 means the
  // transfer is cut off right after that many reads have completed.
  task automatic model_xfer(input logic [31:0] s_in, input logic [31:0] d_in, input int l,
                            input int stop_reads);
    logic [31:0] s, d, data[$];
    int rem, c, reads;
    s = s_in & ~32'd3; d = d_in & ~32'd3; rem = l; reads = 0;
    while (rem > 0) begin
      c = (rem < BURST) ? rem : BURST;
      data.delete();
      for (int i = 0; i < c; i++) begin
        exp_q.push_back({1'b0, s, rd_val(s)});
        data.push_back(rd_val(s));
        s = s + 32'd4;
        reads++;
        if (stop_reads >= 0 && reads == stop_reads) begin
          done_q.push_back(1'b1);
          return;
        end
      end
      for (int i = 0; i < c; i++) begin
        exp_q.push_back({1'b1, d, data[i]});
        d = d + 32'd4;
      end
      rem -= c;
    end
    done_q.push_back(1'b0);
  endtask

  task automatic pulse_start(input logic [31:0] s, input logic [31:0] d, input int l);
    @(posedge clk); #2;
    src_addr = s; dst_addr = d; len = LW'(l); start = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while (done_q.size() != 0 && n < 3000) begin @(posedge clk); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL %s timeout: done not seen, %0d beats pending", nm, exp_q.size());
      done_q.delete();
    end
    check({nm, "_beats_left"}, TW'(exp_q.size()), '0);
    exp_q.delete();
    repeat (3) @(posedge clk);
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (txn_cnt < target && n < 3000) begin @(posedge clk); n++; end
    if (n >= 3000) begin
      total++; bad++;
      $display("FAIL wait_beats timeout: got %0d beats, expected %0d", txn_cnt, target);
    end
  endtask

  // Wishbone slave: ack one beat after a random wait, optional stray acks while idle.
  initial begin
    int wcnt = 0;
    wbm.wbm_ack_i = 1'b0;
    wbm.wbm_dat_i = '0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        wbm.wbm_ack_i = 1'b0;
        wcnt = 0;
      end else begin
        #1;
        if (wbm.wbm_ack_i) begin
          wbm.wbm_ack_i = 1'b0;
          wcnt = $urandom_range(dly_hi, dly_lo);
        end else if (wbm.wbm_cyc_o && wbm.wbm_stb_o) begin
          if (wcnt == 0) begin
            wbm.wbm_ack_i = 1'b1;
            if (!wbm.wbm_we_o) wbm.wbm_dat_i = rd_val(wbm.wbm_adr_o);
          end else wcnt--;
        end else if (noise && $urandom_range(0, 3) == 0) begin
          wbm.wbm_ack_i = 1'b1;
          wbm.wbm_dat_i = $urandom;
        end
      end
    end
  end

  // Monitor: bus beats, cyc release between chunks, completion pulses.
  initial begin
    int low_run = 0;
    bit seen = 0;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (wbm.wbm_cyc_o && wbm.wbm_stb_o && wbm.wbm_ack_i) begin
          txn_cnt++;
          check("beat_sel", TW'(wbm.wbm_sel_o), TW'(4'hF));
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL beat_unexpected: we=%0b adr=%0h", wbm.wbm_we_o, wbm.wbm_adr_o);
          end else begin
            check("beat", {wbm.wbm_we_o, wbm.wbm_adr_o,
                           wbm.wbm_we_o ? wbm.wbm_dat_o : wbm.wbm_dat_i}, exp_q.pop_front());
          end
          if (wbm.wbm_we_o) wmem[wbm.wbm_adr_o] = wbm.wbm_dat_o;
        end
        if (!busy) begin
          seen = 0; low_run = 0;
        end else if (!wbm.wbm_cyc_o) begin
          low_run++;
        end else if (low_run > 0) begin
          if (seen) check("gap_len", TW'(low_run), TW'(1));
          seen = 1; chunk_cnt++; low_run = 0;
        end
        if (done) begin
          check("busy_at_done", TW'(busy), '0);
          if (done_q.size() == 0) begin
            total++; bad++;
            $display("FAIL done_unexpected: aborted=%0b", aborted);
          end else check("aborted", TW'(aborted), TW'(done_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] s, d;
    int l, base;
    seed = $urandom;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ctrl", TW'({busy, done, aborted, wbm.wbm_cyc_o, wbm.wbm_stb_o, wbm.wbm_we_o,
                           wbm.wbm_sel_o}), '0);
    check("rst_adr", TW'(wbm.wbm_adr_o), '0);
    check("rst_dat", TW'(wbm.wbm_dat_o), '0);
    check("rst_state", TW'(state_dbg), '0);
    rst_n = 1'b1;

    // Zero-length transfer: no bus activity, done two cycles after start.
    model_xfer(32'h40, 32'h80, 0, -1);
    pulse_start(32'h40, 32'h80, 0);
    @(negedge clk);
    check("len0_busy", TW'({busy, done, wbm.wbm_cyc_o}), TW'(3'b100));
    @(negedge clk);
    check("len0_done", TW'({busy, done, wbm.wbm_cyc_o}), TW'(3'b010));
    wait_idle("len0");

    model_xfer(32'h100, 32'h200, 3, -1);
    pulse_start(32'h100, 32'h200, 3);
    wait_idle("len3");

    // len=9 with random ack delays: three chunks, one-cycle release between them.
    dly_lo = 0; dly_hi = 5; noise = 1;
    s = 32'h0001_0000 + ($urandom_range(0, 255) << 2) + $urandom_range(0, 3);
    d = 32'h0800_0000 + ($urandom_range(0, 255) << 2);
    chunk_cnt = 0;
    model_xfer(s, d, 9, -1);
    pulse_start(s, d, 9);
    wait_idle("len9");
    check("len9_chunks", TW'(chunk_cnt), TW'(3));
    for (int i = 0; i < 9; i++)
      check("len9_mem", TW'(wmem[d + 32'(4 * i)]), TW'(rd_val((s & ~32'd3) + 32'(4 * i))));

    for (int k = 0; k < 4; k++) begin
      l = $urandom_range(1, 20);
      s = 32'h0002_0000 + ($urandom_range(0, 1023) << 2);
      d = 32'h0900_0000 + ($urandom_range(0, 1023) << 2);
      model_xfer(s, d, l, -1);
      pulse_start(s, d, l);
      wait_idle("rand");
    end
    noise = 0;

    // Abort while the second read of chunk 2 is in flight.
    dly_lo = 3; dly_hi = 3;
    base = txn_cnt;
    model_xfer(32'h5000, 32'h6000, 12, 6);
    pulse_start(32'h5000, 32'h6000, 12);
    wait_beats(base + 9);
    #2 abort = 1'b1;
    @(posedge clk); #2 abort = 1'b0;
    wait_idle("abort");
    repeat (20) @(posedge clk);
    check("abort_beats", TW'(txn_cnt - base), TW'(10));
    check("abort_hold", TW'({busy, aborted, wbm.wbm_cyc_o}), TW'(3'b010));

    // Second start while busy is ignored.
    dly_lo = 0; dly_hi = 2;
    base = txn_cnt;
    model_xfer(32'h7000, 32'h7800, 6, -1);
    pulse_start(32'h7000, 32'h7800, 6);
    wait_beats(base + 2);
    pulse_start(32'hA000, 32'hB000, 2);
    wait_idle("busy_start");
    check("busy_start_aborted", TW'(aborted), '0);

    model_xfer(32'hFFFF_FFF8, 32'h3000, 3, -1);
    pulse_start(32'hFFFF_FFF8, 32'h3000, 3);
    wait_idle("wrap");

    // Reset in the middle of the write phase.
    dly_lo = 1; dly_hi = 1;
    base = txn_cnt;
    model_xfer(32'h8000, 32'h9000, 4, -1);
    pulse_start(32'h8000, 32'h9000, 4);
    wait_beats(base + 5);
    #3 rst_n = 1'b0;
    exp_q.delete(); done_q.delete();
    #1 check("rst_mid_wr", TW'({wbm.wbm_cyc_o, wbm.wbm_stb_o, busy, done}), '0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (2) @(posedge clk);
    model_xfer(32'hC000, 32'hD000, 5, -1);
    pulse_start(32'hC000, 32'hD000, 5);
    wait_idle("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
